// File: rtl/frame_buf_pp.sv
// Double-buffered multi-channel frame buffer: frames of DEPTH beats are
// captured into one bank while the previously committed bank is streamed
// out on a valid/ready interface.
module frame_buf_pp #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int NUM_CH      = 8,
  parameter int ADDR_STRIDE = 2,
  parameter int DEPTH       = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_enabl,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  rd_start,
  output logic                  wr_err,
  output logic                  ovr_err
);

  localparam int WI_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MEM_WORDS = 2 * NUM_CH * DEPTH;
  localparam int MEM_AW    = $clog2(MEM_WORDS);
  localparam logic [WI_W-1:0] LAST_IDX = WI_W'(DEPTH - 1);

  typedef enum logic {IDLE, STREAM} rd_state_t;

  // An address is a channel only when it sits on a stride boundary and the
  // resulting channel number exists.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    int av;
    av = int'(a);
    return ((av % ADDR_STRIDE) == 0) && ((av / ADDR_STRIDE) < NUM_CH);
  endfunction

  function automatic logic [CH_W-1:0] ch_of(input logic [ADDR_WIDTH-1:0] a);
    return CH_W'(int'(a) / ADDR_STRIDE);
  endfunction

  // Flat word address: bank-major, then channel, then beat.
  function automatic logic [MEM_AW-1:0] mem_idx(input logic bank,
                                                input logic [CH_W-1:0] ch,
                                                input logic [WI_W-1:0] i);
    int v;
    v = ((int'(bank) * NUM_CH) + int'(ch)) * DEPTH + int'(i);
    return MEM_AW'(v);
  endfunction

  logic [DATA_WIDTH-1:0] mem [0:MEM_WORDS-1];

  // Write side state
  logic [WI_W-1:0] wi_reg;
  logic            wbank_reg;
  logic [1:0]      full_reg;

  // Read side state
  rd_state_t       state_reg;
  logic            rbank_reg;
  logic [CH_W-1:0] rch_reg;
  logic            rch_ok_reg;
  logic [WI_W-1:0] ri_reg;

  // Combinational control
  logic            wr_ok;
  logic            wr_final;
  logic            rd_done;
  logic            wbank_free;
  logic            store_en;
  logic            commit;
  logic            load;
  logic            ld_bank;
  logic [CH_W-1:0] ld_ch;
  logic            ld_ok;
  logic [WI_W-1:0] ld_idx;

  assign wr_ok    = addr_ok(wr_addr);
  assign wr_final = wr_enabl && (wi_reg == LAST_IDX);
  assign rd_done  = (state_reg == STREAM) && rd_ready && rd_last;

  // The bank being written is usable if nobody holds it, or if the reader
  // hands it back on this very edge.
  assign wbank_free = !full_reg[wbank_reg] || (rd_done && (rbank_reg == wbank_reg));
  // Writes into a bank still owned by the reader are suppressed so a
  // dropped frame cannot corrupt the frame being streamed.
  assign store_en   = wr_enabl && wr_ok && wbank_free;
  assign commit     = wr_final && wbank_free;

  // Select which word the reader fetches next, if any.
  always_comb begin
    load    = 1'b0;
    ld_bank = rbank_reg;
    ld_ch   = rch_reg;
    ld_ok   = rch_ok_reg;
    ld_idx  = ri_reg + WI_W'(1);
    case (state_reg)
      IDLE: begin
        if (full_reg[rbank_reg]) begin
          load   = 1'b1;
          ld_ch  = ch_of(rd_addr);
          ld_ok  = addr_ok(rd_addr);
          ld_idx = '0;
        end
      end
      STREAM: begin
        if (rd_ready) begin
          if (!rd_last) begin
            load = 1'b1;
          end else if (full_reg[~rbank_reg]) begin
            load    = 1'b1;
            ld_bank = ~rbank_reg;
            ld_ch   = ch_of(rd_addr);
            ld_ok   = addr_ok(rd_addr);
            ld_idx  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Frame storage write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (store_en) begin
      mem[mem_idx(wbank_reg, ch_of(wr_addr), wi_reg)] <= wr_data;
    end
  end

  // Write index, bank toggling and write-side error/commit pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wi_reg    <= '0;
      wbank_reg <= 1'b0;
      wr_err    <= 1'b0;
      rd_start  <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      wr_err   <= wr_enabl && !wr_ok;
      rd_start <= commit;
      ovr_err  <= wr_final && !wbank_free;
      if (!wr_enabl || wr_final) begin
        wi_reg <= '0;
      end else begin
        wi_reg <= wi_reg + WI_W'(1);
      end
      if (commit) begin
        wbank_reg <= ~wbank_reg;
      end
    end
  end

  // Bank-full flags: a commit sets the flag, a finished readout clears it;
  // a commit on the same edge as the release wins.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      full_reg <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (commit && (wbank_reg == b[0])) begin
          full_reg[b] <= 1'b1;
        end else if (rd_done && (rbank_reg == b[0])) begin
          full_reg[b] <= 1'b0;
        end
      end
    end
  end

  // Read FSM with registered memory read feeding the output beat.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg  <= IDLE;
      rbank_reg  <= 1'b0;
      rch_reg    <= '0;
      rch_ok_reg <= 1'b0;
      ri_reg     <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else if (load) begin
      state_reg  <= STREAM;
      rbank_reg  <= ld_bank;
      rch_reg    <= ld_ch;
      rch_ok_reg <= ld_ok;
      ri_reg     <= ld_idx;
      rd_data    <= ld_ok ? mem[mem_idx(ld_bank, ld_ch, ld_idx)] : '0;
      rd_valid   <= 1'b1;
      rd_last    <= (ld_idx == LAST_IDX);
    end else if (rd_done) begin
      state_reg <= IDLE;
      rbank_reg <= ~rbank_reg;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_buf_pp.sv
// Directed bench for frame_buf_pp with NUM_CH=4, stride 2, DEPTH 10.
module tb_frame_buf_pp;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int NCH = 4;
  localparam int STR = 2;
  localparam int DEP = 10;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_enabl;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;
  logic          rd_start;
  logic          wr_err;
  logic          ovr_err;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] w_data_arr [DEP];
  logic [AW-1:0] w_addr_arr [DEP];
  logic          exp_bad    [DEP];
  logic [DW-1:0] exp_arr    [DEP];

  frame_buf_pp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_CH     (NCH),
    .ADDR_STRIDE(STR),
    .DEPTH      (DEP)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .wr_data (wr_data),
    .wr_addr (wr_addr),
    .wr_enabl(wr_enabl),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_last (rd_last),
    .rd_start(rd_start),
    .wr_err  (wr_err),
    .ovr_err (ovr_err)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic fill_frame(input logic [DW-1:0] base, input logic [AW-1:0] addr);
    for (int i = 0; i < DEP; i++) begin
      w_data_arr[i] = base + DW'(i);
      w_addr_arr[i] = addr;
      exp_bad[i]    = 1'b0;
      exp_arr[i]    = base + DW'(i);
    end
  endtask

  // Drives nbeats write beats; after each edge checks that edge's pulses.
  task automatic write_frame(input int nbeats, input bit commit, input string tag);
    for (int i = 0; i < nbeats; i++) begin
      wr_enabl = 1'b1;
      wr_addr  = w_addr_arr[i];
      wr_data  = w_data_arr[i];
      step();
      check({tag, "_wr_err"}, 32'(wr_err), 32'(exp_bad[i]));
      check({tag, "_rd_start"}, 32'(rd_start), 32'((i == DEP - 1) && commit));
      check({tag, "_ovr_err"}, 32'(ovr_err), 32'((i == DEP - 1) && !commit));
    end
  endtask

  // Collects DEP handshakes; mode 0 = always ready, mode 1 = ready 1,0,0 repeating.
  task automatic read_frame(input int mode, input string tag, output int steps);
    int k = 0;
    int st = 0;
    bit stalled = 1'b0;
    logic [DW:0] prev = '0;
    while (k < DEP && st < 200) begin
      rd_ready = (mode == 0) || (st % 3 == 0);
      if (stalled) check({tag, "_hold"}, 32'({rd_last, rd_data}), 32'(prev));
      if (rd_valid && rd_ready) begin
        check({tag, "_data"}, 32'(rd_data), 32'(exp_arr[k]));
        check({tag, "_last"}, 32'(rd_last), 32'(k == DEP - 1));
        $display("%s beat %0d data=0x%0h last=%0d", tag, k, rd_data, rd_last);
        k++;
        stalled = 1'b0;
      end else begin
        stalled = rd_valid;
      end
      prev = {rd_last, rd_data};
      step();
      st++;
    end
    check({tag, "_handshakes"}, 32'(k), 32'(DEP));
    steps = st;
  endtask

  initial begin
    int steps;
    rst_n_in = 1'b0;
    wr_data  = '0;
    wr_addr  = '0;
    wr_enabl = 1'b0;
    rd_addr  = 4'h4;
    rd_ready = 1'b0;
    step();
    step();
    check("reset_outputs", 32'({rd_data, rd_valid, rd_last, rd_start, wr_err, ovr_err}), 32'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step();

    // T1: ch2 frame 0..9, always ready, fixed latency, no bubbles
    rd_ready = 1'b1;
    fill_frame(8'h00, 4'h4);
    write_frame(DEP, 1'b1, "t1");
    wr_enabl = 1'b0;
    check("t1_valid_n1", 32'(rd_valid), 32'h0);
    step();
    check("t1_valid_n2", 32'(rd_valid), 32'h1);
    check("t1_beat0_n2", 32'(rd_data), 32'h00);
    read_frame(0, "t1", steps);
    check("t1_cycles", 32'(steps), 32'(DEP));
    check("t1_idle_after", 32'(rd_valid), 32'h0);

    // T2: ch2 frame 0x30.., ready pattern 1,0,0; rd_addr moved mid-stream
    fill_frame(8'h30, 4'h4);
    write_frame(DEP, 1'b1, "t2");
    wr_enabl = 1'b0;
    step();
    rd_addr = 4'h6;
    read_frame(1, "t2", steps);
    for (int c = 0; c < 3; c++) begin
      check("t2_no_extra", 32'(rd_valid), 32'h0);
      step();
    end
    rd_addr = 4'h4;

    // T3: A and B committed while reader stalled, C overruns
    rd_ready = 1'b0;
    fill_frame(8'h10, 4'h4);
    write_frame(DEP, 1'b1, "t3a");
    fill_frame(8'h20, 4'h4);
    write_frame(DEP, 1'b1, "t3b");
    fill_frame(8'hC0, 4'h4);
    write_frame(DEP, 1'b0, "t3c");
    wr_enabl = 1'b0;
    for (int i = 0; i < DEP; i++) exp_arr[i] = 8'h10 + DW'(i);
    read_frame(0, "t3a_rd", steps);
    check("t3_b2b_valid", 32'(rd_valid), 32'h1);
    check("t3_b2b_data", 32'(rd_data), 32'h20);
    for (int i = 0; i < DEP; i++) exp_arr[i] = 8'h20 + DW'(i);
    read_frame(0, "t3b_rd", steps);
    check("t3_idle_after", 32'(rd_valid), 32'h0);

    // T4: 5-beat frame aborted, then a full frame
    fill_frame(8'h40, 4'h4);
    write_frame(5, 1'b0, "t4p");
    wr_enabl = 1'b0;
    step();
    check("t4_no_start", 32'(rd_start), 32'h0);
    check("t4_no_valid", 32'(rd_valid), 32'h0);
    fill_frame(8'h50, 4'h4);
    write_frame(DEP, 1'b1, "t4f");
    wr_enabl = 1'b0;
    read_frame(0, "t4_rd", steps);
    check("t4_idle_after", 32'(rd_valid), 32'h0);

    // T5: bad addresses 3, 8 (channel 4 absent), 0xF; stale 0x2x words remain
    fill_frame(8'h60, 4'h4);
    w_addr_arr[3] = 4'h3; exp_bad[3] = 1'b1; exp_arr[3] = 8'h23;
    w_addr_arr[5] = 4'h8; exp_bad[5] = 1'b1; exp_arr[5] = 8'h25;
    w_addr_arr[7] = 4'hF; exp_bad[7] = 1'b1; exp_arr[7] = 8'h27;
    write_frame(DEP, 1'b1, "t5");
    wr_enabl = 1'b0;
    read_frame(0, "t5_rd", steps);

    // T6: bad read channel gives zeros; async reset mid-stream
    rd_ready = 1'b0;
    rd_addr  = 4'h5;
    fill_frame(8'h70, 4'h4);
    write_frame(DEP, 1'b1, "t6");
    wr_enabl = 1'b0;
    step();
    check("t6_valid", 32'(rd_valid), 32'h1);
    check("t6_badch_zero", 32'(rd_data), 32'h0);
    @(posedge clk_in);
    #3;
    rst_n_in = 1'b0;
    #1;
    check("t6_async_valid", 32'(rd_valid), 32'h0);
    step();
    step();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      check("t6_quiet", 32'({rd_start, rd_valid}), 32'h0);
    end
    rd_addr = 4'h4;
    fill_frame(8'h80, 4'h4);
    write_frame(DEP, 1'b1, "t6f");
    wr_enabl = 1'b0;
    read_frame(0, "t6_rd", steps);
    check("t6_idle_after", 32'(rd_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
